// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer (head + skid).
// Ports: clk, reset (sync, active-high), flush, in_* upstream handshake and
//   entry (pc/a3/data), out_* downstream handshake and head entry; with
//   PIPE_STAGE_STATS_EN defined also stall_cnt/xfer_cnt saturating counters.
module pipe_stage_skid #(
  parameter int unsigned NF       = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_a3,
  input  logic [32*NF-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_a3,
  output logic [32*NF-1:0]  out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      main_pc_q, main_pc_d;
  logic [4:0]       main_a3_q, main_a3_d;
  logic [32*NF-1:0] main_dt_q, main_dt_d;
  logic [31:0]      skid_pc_q, skid_pc_d;
  logic [4:0]       skid_a3_q, skid_a3_d;
  logic [32*NF-1:0] skid_dt_q, skid_dt_d;

  logic in_fire;
  logic out_fire;

  // Both handshake outputs come straight from the state flop, so there is
  // no combinational path from out_ready back to in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_pc   = main_pc_q;
  assign out_a3   = out_valid ? main_a3_q : 5'd0;
  assign out_data = main_dt_q;

  always_comb begin
    state_d   = state_q;
    main_pc_d = main_pc_q;
    main_a3_d = main_a3_q;
    main_dt_d = main_dt_q;
    skid_pc_d = skid_pc_q;
    skid_a3_d = skid_a3_q;
    skid_dt_d = skid_dt_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            main_pc_d = in_pc;
            main_a3_d = in_a3;
            main_dt_d = in_data;
          end
        end
        ONE: begin
          unique case (1'b1)
            in_fire && out_fire: begin
              main_pc_d = in_pc;
              main_a3_d = in_a3;
              main_dt_d = in_data;
            end
            in_fire && !out_fire: begin
              state_d   = FULL;
              skid_pc_d = in_pc;
              skid_a3_d = in_a3;
              skid_dt_d = in_data;
            end
            !in_fire && out_fire: begin
              state_d = EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            state_d   = ONE;
            main_pc_d = skid_pc_q;
            main_a3_d = skid_a3_q;
            main_dt_d = skid_dt_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      main_pc_q <= RESET_PC;
      main_a3_q <= '0;
      main_dt_q <= '0;
      skid_pc_q <= '0;
      skid_a3_q <= '0;
      skid_dt_q <= '0;
    end else begin
      state_q   <= state_d;
      main_pc_q <= main_pc_d;
      main_a3_q <= main_a3_d;
      main_dt_q <= main_dt_d;
      skid_pc_q <= skid_pc_d;
      skid_a3_q <= skid_a3_d;
      skid_dt_q <= skid_dt_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] xfer_q;

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (out_fire && (xfer_q != '1))
        xfer_q <= xfer_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign xfer_cnt  = xfer_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table plus order/flush/stats
// sequences; stats part active when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;
  localparam int NF = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, out_pc;
  logic [4:0] in_a3, out_a3;
  logic [32*NF-1:0] in_data, out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [CW-1:0] stall_cnt, xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .NF(NF),
    .RESET_PC(32'h0000_3000),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_a3(in_a3),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_a3(out_a3),
    .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .xfer_cnt(xfer_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [4:0]  a3;
    logic [31:0] d;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_pc;
    logic [4:0]  e_a3;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [32*NF-1:0] mk_data(input logic [31:0] d);
    logic [32*NF-1:0] r;
    for (int k = 0; k < NF; k++)
      r[32*k +: 32] = d * 32'(k + 1);
    return r;
  endfunction

  initial begin
    logic [32*NF-1:0] ed;
    int n_in, n_out;
    logic [31:0] exp_pc;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_a3 = '0; in_data = '0;

    //        rst  fl   iv   pc          a3  d      ordy ov   ir   e_pc        e_a3 e_d
    tbl[0]  = '{1'b1,1'b0,1'b0,32'h0,      5'd0, 32'h0, 1'b0,1'b0,1'b1,32'h3000,5'd0, 32'h0};
    tbl[1]  = '{1'b0,1'b0,1'b1,32'h3000,   5'd1, 32'h11,1'b1,1'b1,1'b1,32'h3000,5'd1, 32'h11};
    tbl[2]  = '{1'b0,1'b0,1'b1,32'h3004,   5'd2, 32'h22,1'b1,1'b1,1'b1,32'h3004,5'd2, 32'h22};
    tbl[3]  = '{1'b0,1'b0,1'b1,32'h3008,   5'd3, 32'h33,1'b1,1'b1,1'b1,32'h3008,5'd3, 32'h33};
    tbl[4]  = '{1'b0,1'b0,1'b0,32'h0,      5'd0, 32'h0, 1'b1,1'b0,1'b1,32'h3008,5'd0, 32'h33};
    tbl[5]  = '{1'b0,1'b0,1'b1,32'h3000,   5'd5, 32'h55,1'b0,1'b1,1'b1,32'h3000,5'd5, 32'h55};
    tbl[6]  = '{1'b0,1'b0,1'b1,32'h3004,   5'd6, 32'h66,1'b0,1'b1,1'b0,32'h3000,5'd5, 32'h55};
    tbl[7]  = '{1'b0,1'b0,1'b0,32'h0,      5'd0, 32'h0, 1'b0,1'b1,1'b0,32'h3000,5'd5, 32'h55};
    tbl[8]  = '{1'b0,1'b0,1'b0,32'h0,      5'd0, 32'h0, 1'b1,1'b1,1'b1,32'h3004,5'd6, 32'h66};
    tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,      5'd0, 32'h0, 1'b1,1'b0,1'b1,32'h3004,5'd0, 32'h66};
    tbl[10] = '{1'b0,1'b0,1'b1,32'h3010,   5'd8, 32'h88,1'b0,1'b1,1'b1,32'h3010,5'd8, 32'h88};
    tbl[11] = '{1'b0,1'b0,1'b1,32'h3014,   5'd9, 32'h99,1'b0,1'b1,1'b0,32'h3010,5'd8, 32'h88};
    tbl[12] = '{1'b0,1'b1,1'b1,32'h3014,   5'd9, 32'h99,1'b0,1'b0,1'b1,32'h3010,5'd0, 32'h88};
    tbl[13] = '{1'b0,1'b0,1'b0,32'h0,      5'd0, 32'h0, 1'b1,1'b0,1'b1,32'h3010,5'd0, 32'h88};
    tbl[14] = '{1'b0,1'b0,1'b1,32'h3020,   5'd12,32'h0C,1'b0,1'b1,1'b1,32'h3020,5'd12,32'h0C};
    tbl[15] = '{1'b0,1'b1,1'b1,32'h3024,   5'd13,32'h0D,1'b1,1'b0,1'b1,32'h3020,5'd0, 32'h0C};
    tbl[16] = '{1'b0,1'b0,1'b1,32'h3030,   5'd31,32'h1F,1'b1,1'b1,1'b1,32'h3030,5'd31,32'h1F};
    tbl[17] = '{1'b0,1'b0,1'b0,32'h0,      5'd0, 32'h0, 1'b1,1'b0,1'b1,32'h3030,5'd0, 32'h1F};
    tbl[18] = '{1'b0,1'b0,1'b1,32'h3040,   5'd4, 32'h44,1'b0,1'b1,1'b1,32'h3040,5'd4, 32'h44};
    tbl[19] = '{1'b0,1'b0,1'b1,32'h3044,   5'd5, 32'h45,1'b0,1'b1,1'b0,32'h3040,5'd4, 32'h44};
    tbl[20] = '{1'b1,1'b1,1'b0,32'h0,      5'd0, 32'h0, 1'b0,1'b0,1'b1,32'h3000,5'd0, 32'h0};
    tbl[21] = '{1'b0,1'b0,1'b0,32'h0,      5'd0, 32'h0, 1'b1,1'b0,1'b1,32'h3000,5'd0, 32'h0};

    for (int i = 0; i < 22; i++) begin
      reset     = tbl[i].rst;
      flush     = tbl[i].fl;
      in_valid  = tbl[i].iv;
      in_pc     = tbl[i].pc;
      in_a3     = tbl[i].a3;
      in_data   = mk_data(tbl[i].d);
      out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].e_ov));
      chk("in_ready",  i, 32'(in_ready),  32'(tbl[i].e_ir));
      chk("out_pc",    i, out_pc,         tbl[i].e_pc);
      chk("out_a3",    i, 32'(out_a3),    32'(tbl[i].e_a3));
      ed = mk_data(tbl[i].e_d);
      for (int k = 0; k < NF; k++)
        chk("out_data", i, out_data[32*k +: 32], ed[32*k +: 32]);
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;

    // Ordered burst of 8 with downstream ready toggling every cycle.
    n_in = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 100 && n_out < 8; cyc++) begin
      @(negedge clk);
      in_valid  = (n_in < 8);
      in_pc     = 32'h4000 + 32'(4 * n_in);
      in_a3     = 5'(n_in + 1);
      in_data   = mk_data(in_pc);
      out_ready = cyc[0];
      #1;
      if (out_valid && out_ready) begin
        exp_pc = 32'h4000 + 32'(4 * n_out);
        chk("burst_pc", n_out, out_pc, exp_pc);
        chk("burst_a3", n_out, 32'(out_a3), 32'(n_out + 1));
        n_out++;
      end
      if (in_valid && in_ready) n_in++;
    end
    chk("burst_count", 0, 32'(n_out), 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("stall_rst", 0, 32'(stall_cnt), 32'd0);
    in_valid = 1'b1;
    in_pc = 32'h5000;
    in_a3 = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("stall_sat", 0, 32'(stall_cnt), 32'd15);
    chk("xfer_none", 0, 32'(xfer_cnt), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("xfer_one", 0, 32'(xfer_cnt), 32'd1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("stall_flush", 0, 32'(stall_cnt), 32'd15);
    chk("xfer_flush", 0, 32'(xfer_cnt), 32'd1);
    chk("flush_ov", 0, 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("stall_clr", 0, 32'(stall_cnt), 32'd0);
    chk("xfer_clr", 0, 32'(xfer_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
